// File: rtl/pulse_rate_monitor_if.sv
// Signal bundle between the heartbeat front end and the pulse-rate monitor core.
// The master side drives the timebase, sensor input and clear; the slave side publishes results.
interface pulse_rate_monitor_if;
  logic       sclk;
  logic       pulse_in;
  logic       clear;
  logic       beat;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       brady;
  logic       tachy;

  modport master (
    output sclk, pulse_in, clear,
    input  beat, bpm, bpm_valid, brady, tachy
  );

  modport slave (
    input  sclk, pulse_in, clear,
    output beat, bpm, bpm_valid, brady, tachy
  );
endinterface

// File: rtl/pulse_rate_monitor.sv
// Heartbeat rate monitor: synchronises and debounces the sensor on timebase ticks,
// counts beats over a fixed window and publishes saturated BPM with brady/tachy flags.
module pulse_rate_monitor #(
  parameter int WINDOW_TICKS = 1500,
  parameter int BPM_MULT     = 4,
  parameter int DEBOUNCE     = 3,
  parameter int LOW_BPM      = 50,
  parameter int HIGH_BPM     = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  pulse_rate_monitor_if.slave  bus
);

  localparam int TW = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(WINDOW_TICKS - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [7:0]    LOW_T     = 8'(LOW_BPM);
  localparam logic [7:0]    HIGH_T    = 8'(HIGH_BPM);
  localparam logic [15:0]   MULT_W    = 16'(BPM_MULT);

  logic          sclk_q;
  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic          beat_q, beat_d;
  logic [7:0]    bpm_q, bpm_d;
  logic          valid_q, valid_d;
  logic          brady_q, brady_d;
  logic          tachy_q, tachy_d;

  logic          tick;
  logic          rise;
  logic          close;
  logic [7:0]    close_cnt;
  logic [15:0]   bpm_wide;

  always_comb begin
    tick    = bus.sclk & ~sclk_q;
    level_d = level_q;
    deb_d   = deb_q;
    rise    = 1'b0;

    // clear freezes the debounced level and restarts its qualification
    if (bus.clear) begin
      deb_d = '0;
    end else if (tick) begin
      if (sync2_q == level_q) begin
        deb_d = '0;
      end else if (deb_q == DEB_LAST) begin
        level_d = ~level_q;
        deb_d   = '0;
        rise    = ~level_q;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end

    close     = tick & ~bus.clear & (tick_cnt_q == TICK_LAST);
    close_cnt = (rise && (beat_cnt_q != 8'hFF)) ? beat_cnt_q + 8'd1 : beat_cnt_q;
    bpm_wide  = 16'(close_cnt) * MULT_W;

    tick_cnt_d = tick_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (bus.clear || close) begin
      tick_cnt_d = '0;
      beat_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
      beat_cnt_d = close_cnt;
    end

    bpm_d   = bpm_q;
    brady_d = brady_q;
    tachy_d = tachy_q;
    if (close) begin
      bpm_d   = (bpm_wide > 16'd255) ? 8'hFF : bpm_wide[7:0];
      brady_d = (bpm_d < LOW_T);
      tachy_d = (bpm_d > HIGH_T);
    end

    beat_d  = rise;
    valid_d = close;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q     <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      deb_q      <= '0;
      tick_cnt_q <= '0;
      beat_cnt_q <= '0;
      beat_q     <= 1'b0;
      bpm_q      <= '0;
      valid_q    <= 1'b0;
      brady_q    <= 1'b0;
      tachy_q    <= 1'b0;
    end else begin
      sclk_q     <= bus.sclk;
      sync1_q    <= bus.pulse_in;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      deb_q      <= deb_d;
      tick_cnt_q <= tick_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      beat_q     <= beat_d;
      bpm_q      <= bpm_d;
      valid_q    <= valid_d;
      brady_q    <= brady_d;
      tachy_q    <= tachy_d;
    end
  end

  assign bus.beat      = beat_q;
  assign bus.bpm       = bpm_q;
  assign bus.bpm_valid = valid_q;
  assign bus.brady     = brady_q;
  assign bus.tachy     = tachy_q;

endmodule

// File: tb/tb_pulse_rate_monitor.sv
// Directed bench for pulse_rate_monitor: two instances (slow debounce and high multiplier)
// driven by per-tick pulse patterns, with window-level checks on beats, bpm and alarms.
module tb_pulse_rate_monitor;

  logic clk;
  logic reset;

  pulse_rate_monitor_if ifa ();
  pulse_rate_monitor_if ifb ();

  pulse_rate_monitor #(.WINDOW_TICKS(20), .BPM_MULT(4), .DEBOUNCE(3),
                       .LOW_BPM(50), .HIGH_BPM(120))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));

  pulse_rate_monitor #(.WINDOW_TICKS(20), .BPM_MULT(40), .DEBOUNCE(1),
                       .LOW_BPM(50), .HIGH_BPM(120))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int beats_a = 0, beats_b = 0;
  int valid_a = 0, valid_b = 0;
  int cap_bpm_a = 0, cap_bpm_b = 0;
  bit cap_brady_a = 0, cap_brady_b = 0;
  bit cap_tachy_a = 0, cap_tachy_b = 0;

  always @(negedge clk) begin
    if (ifa.beat) beats_a++;
    if (ifb.beat) beats_b++;
    if (ifa.bpm_valid) begin
      valid_a++;
      cap_bpm_a   = ifa.bpm;
      cap_brady_a = ifa.brady;
      cap_tachy_a = ifa.tachy;
    end
    if (ifb.bpm_valid) begin
      valid_b++;
      cap_bpm_b   = ifb.bpm;
      cap_brady_b = ifb.brady;
      cap_tachy_b = ifb.tachy;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One timebase period: input settles in the low phase, tick lands early in the high phase.
  task automatic do_tick(input bit sel, input bit pin);
    if (sel) begin ifb.pulse_in = pin; ifb.sclk = 1'b0; end
    else     begin ifa.pulse_in = pin; ifa.sclk = 1'b0; end
    repeat (4) @(negedge clk);
    if (sel) ifb.sclk = 1'b1; else ifa.sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    bit          sel_b;
    logic [19:0] pat;
    int          beats;
    int          bpm;
    bit          brady;
    bit          tachy;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int v0, b0;
    logic [19:0] pat;

    // bit t of pat is the sensor level sampled on tick t of the window
    vecs[0] = '{0, 20'h00000, 0,   0, 1, 0};  // silent window
    vecs[1] = '{0, 20'hF0F0F, 3,  12, 1, 0};  // 4 high / 4 low, third pulse rises on tick 18
    vecs[2] = '{0, 20'h00C00, 0,   0, 1, 0};  // falls from carried high, then 2-tick glitch
    vecs[3] = '{1, 20'h00005, 2,  80, 0, 0};
    vecs[4] = '{1, 20'h00015, 3, 120, 0, 0};  // exactly at tachy threshold
    vecs[5] = '{1, 20'h00055, 4, 160, 0, 1};
    vecs[6] = '{1, 20'h00001, 1,  40, 1, 0};
    vecs[7] = '{1, 20'h80000, 1,  40, 1, 0};  // rise on the closing tick
    vecs[8] = '{1, 20'h00000, 0,   0, 1, 0};  // next window starts from zero
    vecs[9] = '{1, 20'h01555, 7, 255, 0, 1};  // 280 saturates

    reset = 1'b1;
    ifa.sclk = 0; ifa.pulse_in = 0; ifa.clear = 0;
    ifb.sclk = 0; ifb.pulse_in = 0; ifb.clear = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_bpm_a",   ifa.bpm, 0);
    chk("rst_valid_a", ifa.bpm_valid, 0);
    chk("rst_brady_a", ifa.brady, 0);
    chk("rst_tachy_a", ifa.tachy, 0);
    chk("rst_beat_b",  ifb.beat, 0);
    chk("rst_bpm_b",   ifb.bpm, 0);

    for (int i = 0; i < 10; i++) begin
      pat = vecs[i].pat;
      v0 = vecs[i].sel_b ? valid_b : valid_a;
      b0 = vecs[i].sel_b ? beats_b : beats_a;
      for (int t = 0; t < 20; t++) do_tick(vecs[i].sel_b, pat[t]);
      if (vecs[i].sel_b) begin
        chk($sformatf("v%0d_valid", i), valid_b - v0, 1);
        chk($sformatf("v%0d_beats", i), beats_b - b0, vecs[i].beats);
        chk($sformatf("v%0d_bpm",   i), cap_bpm_b, vecs[i].bpm);
        chk($sformatf("v%0d_brady", i), cap_brady_b, vecs[i].brady);
        chk($sformatf("v%0d_tachy", i), cap_tachy_b, vecs[i].tachy);
      end else begin
        chk($sformatf("v%0d_valid", i), valid_a - v0, 1);
        chk($sformatf("v%0d_beats", i), beats_a - b0, vecs[i].beats);
        chk($sformatf("v%0d_bpm",   i), cap_bpm_a, vecs[i].bpm);
        chk($sformatf("v%0d_brady", i), cap_brady_a, vecs[i].brady);
        chk($sformatf("v%0d_tachy", i), cap_tachy_a, vecs[i].tachy);
      end
    end

    // clear mid-window: old window is abandoned, bpm holds 255 until the post-clear window closes
    v0 = valid_b;
    b0 = beats_b;
    for (int t = 0; t < 10; t++) do_tick(1, (t == 0) || (t == 2));
    chk("clr_pre_beats", beats_b - b0, 2);
    @(negedge clk) ifb.clear = 1'b1;
    @(negedge clk) ifb.clear = 1'b0;
    for (int t = 0; t < 19; t++) do_tick(1, (t == 1) || (t == 3) || (t == 5));
    chk("clr_no_valid", valid_b - v0, 0);
    chk("clr_bpm_hold", ifb.bpm, 255);
    chk("clr_tachy_hold", ifb.tachy, 1);
    do_tick(1, 1'b0);
    chk("clr_valid", valid_b - v0, 1);
    chk("clr_bpm", cap_bpm_b, 120);
    chk("clr_tachy", cap_tachy_b, 0);
    chk("clr_brady", cap_brady_b, 0);

    // asynchronous reset partway through a window, outputs checked before any clk edge
    for (int t = 0; t < 5; t++) do_tick(1, t == 0);
    @(negedge clk);
    ifb.sclk = 1'b0;
    ifa.sclk = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_bpm_b",   ifb.bpm, 0);
    chk("arst_valid_b", ifb.bpm_valid, 0);
    chk("arst_brady_b", ifb.brady, 0);
    chk("arst_tachy_b", ifb.tachy, 0);
    chk("arst_beat_b",  ifb.beat, 0);
    chk("arst_brady_a", ifa.brady, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    v0 = valid_b;
    for (int t = 0; t < 19; t++) do_tick(1, (t == 0) || (t == 2));
    chk("post_rst_no_valid", valid_b - v0, 0);
    do_tick(1, 1'b0);
    chk("post_rst_valid", valid_b - v0, 1);
    chk("post_rst_bpm", cap_bpm_b, 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_rate_monitor.md
Name: pulse_rate_monitor

Overview:
- Consumes the slow square-wave timebase `sclk` from the system clock divider, nominally 100 Hz, in the `clk` domain.
- Conditions the raw heartbeat-sensor input: 2-FF synchroniser, then a debounce sampled on each timebase tick.
- Counts beats over a fixed window and converts the count to beats per minute.
- Publishes `bpm` with a valid strobe and brady/tachy alarm flags to the display/alarm logic downstream.

Parameters:
- WINDOW_TICKS, 1500: timebase ticks per measurement window (15 s at 100 Hz).
- BPM_MULT, 4: multiplier from window beat count to BPM (60 s / window length).
- DEBOUNCE, 3: consecutive ticks a changed input must hold before it is accepted (≥1).
- LOW_BPM, 50: brady threshold, compared strictly below.
- HIGH_BPM, 120: tachy threshold, compared strictly above.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- sclk  in  1  timebase square wave, registered in the clk domain
- pulse_in  in  1  raw sensor pulse, asynchronous
- clear  in  1  synchronous window restart, one-cycle pulse
- beat  out  1  one-cycle strobe per accepted beat
- bpm  out  8  last completed-window rate, saturated at 255
- bpm_valid  out  1  one-cycle strobe when `bpm` updates
- brady  out  1  bpm < LOW_BPM, updated with bpm
- tachy  out  1  bpm > HIGH_BPM, updated with bpm

Behaviour:
- Interface: one clock `clk`. `reset` is asynchronous and active-high. All state clears immediately on assertion, regardless of `clk`.
- Reset values:
  - Outputs: beat=0, bpm=0, bpm_valid=0, brady=0, tachy=0.
  - Internal: sync flops=0, debounced level=0, debounce count=0, tick count=0, beat count=0, sclk history=0.
- Tick:
  - sclk_d <= sclk every cycle.
  - tick = sclk & ~sclk_d (combinational).
  - All tick-qualified state updates occur on the clk edge where tick=1.
  - Exactly one tick per sclk rising edge. A constant sclk produces no ticks.
- Synchroniser: pulse_in passes through 2 flops every clk cycle, not only on ticks.
- Debounce, per tick:
  - If sync value == debounced level: debounce count <= 0.
  - Otherwise debounce count increments. When the count reaches DEBOUNCE-1 on this tick, the level flips and the count goes to 0.
  - Net effect: a new level is accepted on the DEBOUNCE-th consecutive differing tick.
- Beat detection:
  - A debounced 0→1 transition is a beat. beat=1 for the single cycle after that edge.
  - Beat count increments and saturates at 255.
  - A 1→0 transition produces nothing.
- Window:
  - Tick count runs 0..WINDOW_TICKS-1.
  - On the tick where tick count == WINDOW_TICKS-1:
    - The closing count includes any beat accepted on this same tick.
    - bpm <= min(closing_count*BPM_MULT, 255). Compute at ≥16 bits before saturating.
    - brady/tachy are computed from the saturated value.
    - Tick count and beat count go to 0.
    - bpm_valid=1 on the following cycle only.
  - No partial-window result is ever published.
- clear:
  - Zeroes tick count, beat count and debounce count.
  - bpm, alarms and debounced level hold.
  - No bpm_valid is generated.
  - clear coincident with a window-closing tick: clear wins; no publish.
- Reset mid-window: the window is discarded. The next window is full length, measured from the first tick after reset release.
- Zero beats in a window: bpm=0, brady=1, tachy=0.

Test Plan:
- Assert reset mid-operation with no clk edge → all outputs 0 immediately. After release, no bpm_valid until WINDOW_TICKS ticks have elapsed.
- WINDOW_TICKS=20, DEBOUNCE=3, 3 clean pulses each 4 ticks high / 4 low → beat strobes 3 times; one bpm_valid at window end; bpm=12, brady=1, tachy=0.
- DEBOUNCE=3, pulse high for 2 ticks then low → no beat; debounced level stays 0; bpm=0 at window end.
- WINDOW_TICKS=20, DEBOUNCE=1, BPM_MULT=40, 7 beats → bpm=255 (280 saturated), tachy=1, brady=0.
- Debounced rise accepted on the final tick of window N → beat counted in window N (bpm includes it); window N+1 starts at count 0.
- Assert clear at tick 10 of a 20-tick window after 2 beats → no bpm_valid at tick 19. Next publish comes 20 ticks after clear and counts only post-clear beats. bpm holds its prior value meanwhile.
